// File: rtl/mantissa_norm_round.sv
// mantissa_norm_round
//
// Purpose:
//   Normalizes and rounds the raw 56-bit product from the 28x28 mantissa
//   multiplier. The block runs as a two-stage valid/ready pipeline.
//     S1: selects the normalize window and captures guard (G) and sticky (S).
//         It also captures the zero and unnormalized flags.
//     S2: applies the rounding increment, handles carry-out of an all-ones
//         mantissa, and registers the final result.
//   The product is treated either as one 28-bit lane (single) or as two
//   independent 14-bit lanes (dual). In dual mode, lane0 is built from
//   prod[27:0] and lane1 from prod[55:28].
//
// Ports:
//   clk, rst        single clock; asynchronous active-high reset
//   s_valid/s_ready input handshake
//   s_prod [55:0]   raw mantissa product
//   s_op   [1:0]    00 single RNE, 01 single trunc, 10 dual RNE, 11 dual trunc
//   s_tag           sideband tag, carried through unchanged
//   m_valid/m_ready output handshake
//   m_mant [27:0]   rounded mantissa including the hidden bit
//                   (dual mode: lane1 in [27:14], lane0 in [13:0])
//   m_eadj [3:0]    per-lane exponent adjust, 0..2 (lane0 in [1:0])
//   m_inexact/m_zero/m_unnorm [1:0]  per-lane flags (bit 1 is 0 in single mode)
//   m_op, m_tag     s_op and s_tag, registered alongside the result
//
// Handshake:
//   A transfer happens on a rising edge where valid and ready are both high.
//   A stage loads when it is empty or when its downstream stage drains.
//   The contents of a stalled stage do not change.
//   s_ready = !s1_valid | s2_load, where s2_load = !s2_valid | m_ready.
module mantissa_norm_round #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [55:0]      s_prod,
    input  logic [1:0]       s_op,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [27:0]      m_mant,
    output logic [3:0]       m_eadj,
    output logic [1:0]       m_inexact,
    output logic [1:0]       m_zero,
    output logic [1:0]       m_unnorm,
    output logic [1:0]       m_op,
    output logic [TAG_W-1:0] m_tag
);

    // Normalize result for one 28-bit dual-mode lane.
    typedef struct packed {
        logic [13:0] mant;
        logic        g;
        logic        s;
        logic        hi;      // lane MSB was set; sets the eadj base to 1
        logic        zero;
        logic        unnorm;
    } lane_norm_t;

    function automatic lane_norm_t norm_lane(input logic [27:0] l);
        lane_norm_t r;
        r.hi = l[27];
        if (l[27]) begin
            r.mant = l[27:14];
            r.g    = l[13];
            r.s    = |l[12:0];
        end else begin
            r.mant = l[26:13];
            r.g    = l[12];
            r.s    = |l[11:0];
        end
        r.zero   = (l == 28'd0);
        r.unnorm = !r.zero && (l[27:26] == 2'b00);
        return r;
    endfunction

    // Round one 14-bit lane. The return value is {eadj[1:0], mant[13:0]}.
    // Carry-out can occur only when the mantissa is all ones. The result then
    // becomes the hidden bit alone, and the exponent adjust goes up by one.
    function automatic logic [15:0] round_lane(
        input logic [13:0] mant,
        input logic        g,
        input logic        s,
        input logic        hi,
        input logic        trunc
    );
        logic        up;
        logic [14:0] sum;
        logic [1:0]  e;
        logic [13:0] m;
        up  = !trunc && g && (s || mant[0]);
        sum = {1'b0, mant} + {14'd0, up};
        e   = {1'b0, hi};
        m   = sum[13:0];
        if (sum[14]) begin
            m = 14'h2000;
            e = e + 2'd1;
        end
        return {e, m};
    endfunction

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_load;
    logic s1_load;
    logic s1_take;
    logic s2_take;

    always_comb begin
        s2_load    = !s2_valid_q || m_ready;
        s1_load    = !s1_valid_q || s2_load;
        s1_take    = s_valid && s1_load;
        s2_take    = s1_valid_q && s2_load;
        s1_valid_d = s1_load ? s_valid : s1_valid_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    end

    assign s_ready = s1_load;
    assign m_valid = s2_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: normalize window selection, guard and sticky bits
    // ------------------------------------------------------------------
    logic [27:0]      s1_mant_q,   s1_mant_d;
    logic [1:0]       s1_g_q,      s1_g_d;
    logic [1:0]       s1_s_q,      s1_s_d;
    logic [1:0]       s1_hi_q,     s1_hi_d;
    logic [1:0]       s1_zero_q,   s1_zero_d;
    logic [1:0]       s1_unnorm_q, s1_unnorm_d;
    logic [1:0]       s1_op_q,     s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,    s1_tag_d;

    lane_norm_t lane0_n;
    lane_norm_t lane1_n;
    logic       sgl_hi;
    logic       sgl_zero;

    always_comb begin
        lane0_n  = norm_lane(s_prod[27:0]);
        lane1_n  = norm_lane(s_prod[55:28]);
        sgl_hi   = s_prod[55];
        sgl_zero = (s_prod == 56'd0);

        s1_mant_d   = s1_mant_q;
        s1_g_d      = s1_g_q;
        s1_s_d      = s1_s_q;
        s1_hi_d     = s1_hi_q;
        s1_zero_d   = s1_zero_q;
        s1_unnorm_d = s1_unnorm_q;
        s1_op_d     = s1_op_q;
        s1_tag_d    = s1_tag_q;

        if (s1_take) begin
            s1_op_d  = s_op;
            s1_tag_d = s_tag;
            if (s_op[1]) begin
                s1_mant_d   = {lane1_n.mant, lane0_n.mant};
                s1_g_d      = {lane1_n.g, lane0_n.g};
                s1_s_d      = {lane1_n.s, lane0_n.s};
                s1_hi_d     = {lane1_n.hi, lane0_n.hi};
                s1_zero_d   = {lane1_n.zero, lane0_n.zero};
                s1_unnorm_d = {lane1_n.unnorm, lane0_n.unnorm};
            end else begin
                // Single lane. Lane1 bits are forced to 0, so the flags and
                // eadj read as 0 in the upper lane.
                if (sgl_hi) begin
                    s1_mant_d = s_prod[55:28];
                    s1_g_d    = {1'b0, s_prod[27]};
                    s1_s_d    = {1'b0, |s_prod[26:0]};
                end else begin
                    s1_mant_d = s_prod[54:27];
                    s1_g_d    = {1'b0, s_prod[26]};
                    s1_s_d    = {1'b0, |s_prod[25:0]};
                end
                s1_hi_d     = {1'b0, sgl_hi};
                s1_zero_d   = {1'b0, sgl_zero};
                s1_unnorm_d = {1'b0, !sgl_zero && (s_prod[55:54] == 2'b00)};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: rounding and carry-out handling
    // ------------------------------------------------------------------
    logic [27:0]      s2_mant_q,    s2_mant_d;
    logic [3:0]       s2_eadj_q,    s2_eadj_d;
    logic [1:0]       s2_inexact_q, s2_inexact_d;
    logic [1:0]       s2_zero_q,    s2_zero_d;
    logic [1:0]       s2_unnorm_q,  s2_unnorm_d;
    logic [1:0]       s2_op_q,      s2_op_d;
    logic [TAG_W-1:0] s2_tag_q,     s2_tag_d;

    logic        trunc;
    logic [15:0] r_lane0;
    logic [15:0] r_lane1;
    logic        sgl_up;
    logic [28:0] sgl_sum;
    logic [1:0]  sgl_eadj;
    logic [27:0] sgl_mant;

    always_comb begin
        trunc   = s1_op_q[0];
        r_lane0 = round_lane(s1_mant_q[13:0],  s1_g_q[0], s1_s_q[0], s1_hi_q[0], trunc);
        r_lane1 = round_lane(s1_mant_q[27:14], s1_g_q[1], s1_s_q[1], s1_hi_q[1], trunc);

        sgl_up   = !trunc && s1_g_q[0] && (s1_s_q[0] || s1_mant_q[0]);
        sgl_sum  = {1'b0, s1_mant_q} + {28'd0, sgl_up};
        sgl_eadj = {1'b0, s1_hi_q[0]};
        sgl_mant = sgl_sum[27:0];
        if (sgl_sum[28]) begin
            sgl_mant = 28'h800_0000;
            sgl_eadj = sgl_eadj + 2'd1;
        end

        s2_mant_d    = s2_mant_q;
        s2_eadj_d    = s2_eadj_q;
        s2_inexact_d = s2_inexact_q;
        s2_zero_d    = s2_zero_q;
        s2_unnorm_d  = s2_unnorm_q;
        s2_op_d      = s2_op_q;
        s2_tag_d     = s2_tag_q;

        if (s2_take) begin
            s2_op_d      = s1_op_q;
            s2_tag_d     = s1_tag_q;
            s2_zero_d    = s1_zero_q;
            s2_unnorm_d  = s1_unnorm_q;
            s2_inexact_d = s1_g_q | s1_s_q;
            if (s1_op_q[1]) begin
                s2_mant_d = {r_lane1[13:0], r_lane0[13:0]};
                s2_eadj_d = {r_lane1[15:14], r_lane0[15:14]};
            end else begin
                s2_mant_d = sgl_mant;
                s2_eadj_d = {2'b00, sgl_eadj};
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers. Data is cleared too, so the outputs read 0 in reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_mant_q    <= '0;
            s1_g_q       <= '0;
            s1_s_q       <= '0;
            s1_hi_q      <= '0;
            s1_zero_q    <= '0;
            s1_unnorm_q  <= '0;
            s1_op_q      <= '0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_mant_q    <= '0;
            s2_eadj_q    <= '0;
            s2_inexact_q <= '0;
            s2_zero_q    <= '0;
            s2_unnorm_q  <= '0;
            s2_op_q      <= '0;
            s2_tag_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_mant_q    <= s1_mant_d;
            s1_g_q       <= s1_g_d;
            s1_s_q       <= s1_s_d;
            s1_hi_q      <= s1_hi_d;
            s1_zero_q    <= s1_zero_d;
            s1_unnorm_q  <= s1_unnorm_d;
            s1_op_q      <= s1_op_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_mant_q    <= s2_mant_d;
            s2_eadj_q    <= s2_eadj_d;
            s2_inexact_q <= s2_inexact_d;
            s2_zero_q    <= s2_zero_d;
            s2_unnorm_q  <= s2_unnorm_d;
            s2_op_q      <= s2_op_d;
            s2_tag_q     <= s2_tag_d;
        end
    end

    assign m_mant    = s2_mant_q;
    assign m_eadj    = s2_eadj_q;
    assign m_inexact = s2_inexact_q;
    assign m_zero    = s2_zero_q;
    assign m_unnorm  = s2_unnorm_q;
    assign m_op      = s2_op_q;
    assign m_tag     = s2_tag_q;

endmodule

// File: tb/tb_mantissa_norm_round.sv
// Directed testbench for mantissa_norm_round.
// Output records are packed as {mant, eadj, inexact, zero, unnorm, op, tag}.
module tb_mantissa_norm_round;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [55:0]      s_prod;
    logic [1:0]       s_op;
    logic [TAG_W-1:0] s_tag;
    logic             m_valid;
    logic             m_ready;
    logic [27:0]      m_mant;
    logic [3:0]       m_eadj;
    logic [1:0]       m_inexact;
    logic [1:0]       m_zero;
    logic [1:0]       m_unnorm;
    logic [1:0]       m_op;
    logic [TAG_W-1:0] m_tag;

    logic [43:0] obs;
    logic [43:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Product patterns
    localparam logic [55:0] P_ONE   = 56'h80000000000000;
    localparam logic [55:0] P_ALL1  = 56'hFFFFFFFC000000;
    localparam logic [55:0] P_TIE   = 56'h40000004000000;
    localparam logic [55:0] P_ODD   = 56'h4000000C000000;
    localparam logic [55:0] P_LOC   = 56'h7FFFFFFC000000;
    localparam logic [55:0] P_DUN   = 56'h80000000000001;
    localparam logic [55:0] P_DCY   = 56'h4002000FFFE000;

    mantissa_norm_round #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_prod    (s_prod),
        .s_op      (s_op),
        .s_tag     (s_tag),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_mant    (m_mant),
        .m_eadj    (m_eadj),
        .m_inexact (m_inexact),
        .m_zero    (m_zero),
        .m_unnorm  (m_unnorm),
        .m_op      (m_op),
        .m_tag     (m_tag)
    );

    assign obs = {m_mant, m_eadj, m_inexact, m_zero, m_unnorm, m_op, m_tag};

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [43:0] rec(
        input logic [27:0] mant, input logic [3:0] eadj, input logic [1:0] inex,
        input logic [1:0] zero, input logic [1:0] unnorm, input logic [1:0] op,
        input logic [3:0] tag);
        return {mant, eadj, inex, zero, unnorm, op, tag};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    endtask

    // Scoreboard: every accepted output pops the expected queue in order
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("out_record", 64'(obs), 64'(exp_q.pop_front()));
        end
    end

    // Driver: called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [55:0] p, input logic [1:0] op,
                        input logic [3:0] tag, input logic [43:0] exp, input bit push);
        int g;
        s_valid = 1'b1;
        s_prod  = p;
        s_op    = op;
        s_tag   = tag;
        if (push) exp_q.push_back(exp);
        g = 0;
        @(negedge clk);
        while (!s_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("send_accept", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_prod  = '0;
        s_op    = '0;
        s_tag   = '0;
        m_ready = 1'b1;

        // Outputs while reset is held
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_m_mant",  64'(m_mant),  64'd0);
        chk("rst_m_eadj",  64'(m_eadj),  64'd0);
        chk("rst_flags",   64'({m_inexact, m_zero, m_unnorm}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_m_valid", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;

        // Latency: accepted at edge 1, visible after edge 2
        send(P_ONE, 2'b00, 4'h1, rec(28'h8000000, 4'h1, 2'b00, 2'b00, 2'b00, 2'b00, 4'h1), 1'b1);
        @(negedge clk);
        chk("lat_cycle1_m_valid", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_m_valid", 64'(m_valid), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors at full rate
        send(P_ALL1, 2'b00, 4'h2, rec(28'h8000000, 4'h2, 2'b01, 2'b00, 2'b00, 2'b00, 4'h2), 1'b1);
        send(P_ALL1, 2'b01, 4'h3, rec(28'hFFFFFFF, 4'h1, 2'b01, 2'b00, 2'b00, 2'b01, 4'h3), 1'b1);
        send(P_TIE,  2'b00, 4'h4, rec(28'h8000000, 4'h0, 2'b01, 2'b00, 2'b00, 2'b00, 4'h4), 1'b1);
        send(P_ODD,  2'b00, 4'h5, rec(28'h8000002, 4'h0, 2'b01, 2'b00, 2'b00, 2'b00, 4'h5), 1'b1);
        send(P_ODD,  2'b01, 4'h6, rec(28'h8000001, 4'h0, 2'b01, 2'b00, 2'b00, 2'b01, 4'h6), 1'b1);
        send(56'h0,  2'b00, 4'h7, rec(28'h0000000, 4'h0, 2'b00, 2'b01, 2'b00, 2'b00, 4'h7), 1'b1);
        send(56'h1,  2'b00, 4'h8, rec(28'h0000000, 4'h0, 2'b01, 2'b00, 2'b01, 2'b00, 4'h8), 1'b1);
        send(P_LOC,  2'b00, 4'h9, rec(28'h8000000, 4'h1, 2'b01, 2'b00, 2'b00, 2'b00, 4'h9), 1'b1);
        send(P_ONE,  2'b10, 4'hA, rec(28'h8000000, 4'h4, 2'b00, 2'b01, 2'b00, 2'b10, 4'hA), 1'b1);
        send(P_DUN,  2'b10, 4'hB, rec(28'h8000000, 4'h4, 2'b01, 2'b00, 2'b01, 2'b10, 4'hB), 1'b1);
        send(P_DCY,  2'b10, 4'hC, rec(28'h8006000, 4'h2, 2'b01, 2'b00, 2'b00, 2'b10, 4'hC), 1'b1);
        send(P_DCY,  2'b11, 4'hD, rec(28'h8007FFF, 4'h1, 2'b01, 2'b00, 2'b00, 2'b11, 4'hD), 1'b1);
        send(56'h0,  2'b11, 4'hE, rec(28'h0000000, 4'h0, 2'b00, 2'b11, 2'b00, 2'b11, 4'hE), 1'b1);
        drain();

        // Backpressure: 6 back-to-back inputs, m_ready low for three edges
        fork
            begin
                send(P_ONE,  2'b00, 4'h0, rec(28'h8000000, 4'h1, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0), 1'b1);
                send(P_TIE,  2'b00, 4'h1, rec(28'h8000000, 4'h0, 2'b01, 2'b00, 2'b00, 2'b00, 4'h1), 1'b1);
                send(P_ODD,  2'b00, 4'h2, rec(28'h8000002, 4'h0, 2'b01, 2'b00, 2'b00, 2'b00, 4'h2), 1'b1);
                send(P_ONE,  2'b10, 4'h3, rec(28'h8000000, 4'h4, 2'b00, 2'b01, 2'b00, 2'b10, 4'h3), 1'b1);
                send(P_DCY,  2'b10, 4'h4, rec(28'h8006000, 4'h2, 2'b01, 2'b00, 2'b00, 2'b10, 4'h4), 1'b1);
                send(P_LOC,  2'b00, 4'h5, rec(28'h8000000, 4'h1, 2'b01, 2'b00, 2'b00, 2'b00, 4'h5), 1'b1);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                m_ready = 1'b0;
                @(negedge clk);
                chk("bp_s_ready_low", 64'(s_ready), 64'd0);
                chk("bp_m_valid_held", 64'(m_valid), 64'd1);
                @(posedge clk);
                @(posedge clk);
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full; the in-flight results are discarded
        m_ready = 1'b0;
        send(P_ALL1, 2'b00, 4'hE, '0, 1'b0);
        send(P_TIE,  2'b00, 4'hF, '0, 1'b0);
        chk("full_m_valid", 64'(m_valid), 64'd1);
        chk("full_s_ready", 64'(s_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_s_ready", 64'(s_ready), 64'd1);
        chk("midrst_m_mant",  64'(m_mant),  64'd0);
        chk("midrst_m_eadj",  64'(m_eadj),  64'd0);
        chk("midrst_flags",   64'({m_inexact, m_zero, m_unnorm}), 64'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale_m_valid", 64'(m_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(P_ODD, 2'b01, 4'h7, rec(28'h8000001, 4'h0, 2'b01, 2'b00, 2'b00, 2'b01, 4'h7), 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
